// File: rtl/bram_test_pkg.sv
// Shared definitions for the BRAM test sequencer: FSM state encoding and
// the default data-pattern seed.
package bram_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [31:0] DEFAULT_PATTERN_SEED = 32'hA5C3_5A3C;

endpackage

// File: rtl/bram_test_watchdog.sv
// Saturating busy-cycle counter; expired_o stays high once the limit is reached
// until the next clear.
module bram_test_watchdog #(
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values of its inputs, independent of block ordering.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_count <= '0;
      end else if (clear_i) begin
         r_count <= '0;
      end else if (enable_i && (r_count != LIMIT)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign expired_o = (r_count == LIMIT);

endmodule

// File: rtl/bram_test_sequencer.sv
// Two-pass BRAM write/read-back tester: pass 0 writes addr^seed, pass 1 writes
// its inverse; each pass is read back and compared, guarded by a watchdog.
module bram_test_sequencer
   import bram_test_pkg::*;
#(
   parameter int          ADDR_W         = 4,
   parameter int          DATA_W         = 32,
   parameter int          TIMEOUT_CYCLES = 50000000,
   parameter logic [31:0] PATTERN_SEED   = DEFAULT_PATTERN_SEED
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic              bram_we_o,
   output logic [DATA_W-1:0] bram_wdata_o,
   input  logic [DATA_W-1:0] bram_rdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              fail_o,
   output logic              timed_out_o,
   output logic [ADDR_W-1:0] err_addr_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr,
                                                  input logic            pass_idx);
      logic [DATA_W-1:0] v;
      v = DATA_W'(addr) ^ DATA_W'(PATTERN_SEED);
      return pass_idx ? ~v : v;
   endfunction

   state_t            r_state;
   state_t            w_next_state;
   logic              r_pass_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_exp;
   logic [ADDR_W-1:0] r_cmp_addr;
   logic              r_cmp_valid;
   logic              r_pass;
   logic              r_fail;
   logic              r_timed_out;
   logic [ADDR_W-1:0] r_err_addr;

   logic              w_accept;
   logic              w_busy;
   logic              w_expired;
   logic              w_miscompare;
   logic              w_we;
   logic              w_done;
   logic [DATA_W-1:0] w_wdata;

   assign w_accept     = (r_state == ST_IDLE) && start_i;
   // Read data lags the address by one cycle, so compare against the registered copy.
   assign w_miscompare = r_cmp_valid && (bram_rdata_i != r_exp);

   bram_test_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (w_accept),
      .enable_i  (w_busy),
      .expired_o (w_expired)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b0;
      w_we         = 1'b0;
      w_wdata      = '0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) w_next_state = ST_WRITE;
         end
         ST_WRITE: begin
            w_busy  = 1'b1;
            w_we    = 1'b1;
            w_wdata = pattern(r_addr, r_pass_idx);
            if (w_expired)                w_next_state = ST_DONE;
            else if (r_addr == LAST_ADDR) w_next_state = ST_READ;
         end
         ST_READ: begin
            w_busy = 1'b1;
            if (w_expired || w_miscompare) w_next_state = ST_DONE;
            else if (r_addr == LAST_ADDR)  w_next_state = ST_CHECK;
         end
         ST_CHECK: begin
            w_busy = 1'b1;
            if (w_expired || w_miscompare || r_pass_idx) w_next_state = ST_DONE;
            else                                         w_next_state = ST_WRITE;
         end
         ST_DONE: begin
            w_done       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_pass_idx  <= 1'b0;
         r_addr      <= '0;
         r_exp       <= '0;
         r_cmp_addr  <= '0;
         r_cmp_valid <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_timed_out <= 1'b0;
         r_err_addr  <= '0;
      end else begin
         r_cmp_valid <= (r_state == ST_READ);
         if (r_state == ST_READ) begin
            r_exp      <= pattern(r_addr, r_pass_idx);
            r_cmp_addr <= r_addr;
         end

         if ((r_state == ST_WRITE) || (r_state == ST_READ)) r_addr <= r_addr + ADDR_W'(1);
         else                                                 r_addr <= '0;

         if (w_accept)                                             r_pass_idx <= 1'b0;
         else if ((r_state == ST_CHECK) && (w_next_state == ST_WRITE)) r_pass_idx <= 1'b1;

         // Expiry outranks a same-cycle miscompare and leaves err_addr untouched.
         if (w_accept) begin
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timed_out <= 1'b0;
            r_err_addr  <= '0;
         end else if (w_busy && w_expired) begin
            r_timed_out <= 1'b1;
            r_fail      <= 1'b1;
         end else if (w_busy && w_miscompare) begin
            r_fail      <= 1'b1;
            r_err_addr  <= r_cmp_addr;
         end else if ((r_state == ST_CHECK) && r_pass_idx) begin
            r_pass      <= 1'b1;
         end
      end
   end

   assign bram_addr_o  = r_addr;
   assign bram_we_o    = w_we;
   assign bram_wdata_o = w_wdata;
   assign busy_o       = w_busy;
   assign done_o       = w_done;
   assign pass_o       = r_pass;
   assign fail_o       = r_fail;
   assign timed_out_o  = r_timed_out;
   assign err_addr_o   = r_err_addr;

endmodule

// File: tb/tb_bram_test_sequencer.sv
// Directed bench: clean run, injected read fault, held start, mid-run reset,
// and a short-watchdog instance, each against hand-computed cycle counts.
module tb_bram_test_sequencer;

   localparam int          ADDR_W = 4;
   localparam int          DATA_W = 32;
   localparam int          N      = 16;
   localparam logic [31:0] SEED   = 32'hA5C3_5A3C;

   logic clk = 1'b0;
   logic reset_n;
   logic start_a, start_b;

   logic [ADDR_W-1:0] addr_a, err_a, addr_b, err_b;
   logic              we_a, busy_a, done_a, pass_a, fail_a, to_a;
   logic              we_b, busy_b, done_b, pass_b, fail_b, to_b;
   logic [DATA_W-1:0] wdata_a, rdata_a, wdata_b, rdata_b;

   logic              fault_en;
   logic [ADDR_W-1:0] fault_addr;
   logic [1:0]        sweep_a;
   logic [DATA_W-1:0] mem_a [N];
   logic [DATA_W-1:0] mem_b [N];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int n_done_a = 0;
   int cyc;
   int done_base;

   always #5 clk = ~clk;

   bram_test_sequencer u_dut_a (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .start_i      (start_a),
      .bram_addr_o  (addr_a),
      .bram_we_o    (we_a),
      .bram_wdata_o (wdata_a),
      .bram_rdata_i (rdata_a),
      .busy_o       (busy_a),
      .done_o       (done_a),
      .pass_o       (pass_a),
      .fail_o       (fail_a),
      .timed_out_o  (to_a),
      .err_addr_o   (err_a)
   );

   bram_test_sequencer #(.TIMEOUT_CYCLES(20)) u_dut_b (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .start_i      (start_b),
      .bram_addr_o  (addr_b),
      .bram_we_o    (we_b),
      .bram_wdata_o (wdata_b),
      .bram_rdata_i (rdata_b),
      .busy_o       (busy_b),
      .done_o       (done_b),
      .pass_o       (pass_b),
      .fail_o       (fail_b),
      .timed_out_o  (to_b),
      .err_addr_o   (err_b)
   );

   // BRAM model A: registered read; optional bit-0 stuck-at-1 during the second write sweep (pass 1).
   always @(posedge clk) begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      rdata_a <= (fault_en && (sweep_a == 2'd2) && (addr_a == fault_addr))
                 ? (mem_a[addr_a] | 32'h1) : mem_a[addr_a];
      if (!busy_a)                        sweep_a <= 2'd0;
      else if (we_a && (addr_a == 4'd0))  sweep_a <= sweep_a + 2'd1;
   end

   always @(posedge clk) begin
      if (we_b) mem_b[addr_b] <= wdata_b;
      rdata_b <= mem_b[addr_b];
   end

   always @(negedge clk) if (done_a === 1'b1) n_done_a <= n_done_a + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done_a(input int cyc0, input int bound, output int c);
      c = cyc0;
      while ((done_a !== 1'b1) && (c < bound)) begin
         tick();
         c++;
      end
   endtask

   task automatic wait_done_b(input int cyc0, input int bound, output int c);
      c = cyc0;
      while ((done_b !== 1'b1) && (c < bound)) begin
         tick();
         c++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      start_a    = 1'b0;
      start_b    = 1'b0;
      fault_en   = 1'b0;
      fault_addr = 4'd5;
      tick();
      tick();
      check("reset_outputs", {busy_a, done_a, pass_a, fail_a, to_a, we_a, addr_a, err_a, wdata_a}, 64'd0);
      reset_n = 1'b1;
      tick();

      // Clean run: start sampled in cycle 0.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("c1_write0", {busy_a, we_a, addr_a, wdata_a}, {1'b1, 1'b1, 4'd0, SEED});
      tick();
      check("c2_write1", {we_a, addr_a, wdata_a}, {1'b1, 4'd1, SEED ^ 32'd1});
      repeat (15) tick();
      check("c17_read0", {busy_a, we_a, addr_a}, {1'b1, 1'b0, 4'd0});
      repeat (16) tick();
      check("c33_check", {busy_a, we_a, done_a}, {1'b1, 1'b0, 1'b0});
      tick();
      check("c34_write_p1", {we_a, addr_a, wdata_a}, {1'b1, 4'd0, ~SEED});
      wait_done_a(34, 200, cyc);
      check("clean_done_cycle", cyc, 67);
      check("clean_flags", {pass_a, fail_a, to_a, busy_a}, {1'b1, 1'b0, 1'b0, 1'b0});
      tick();
      check("clean_after_done", {done_a, busy_a, pass_a}, {1'b0, 1'b0, 1'b1});

      // Bit-0 stuck-at-1 at address 5 in pass 1.
      fault_en = 1'b1;
      start_a  = 1'b1;
      tick();
      start_a = 1'b0;
      check("fault_flags_cleared", {pass_a, fail_a}, 2'b00);
      wait_done_a(1, 200, cyc);
      check("fault_done_cycle", cyc, 57);
      check("fault_flags", {fail_a, pass_a, to_a, err_a}, {1'b1, 1'b0, 1'b0, 4'd5});
      tick();
      fault_en = 1'b0;

      // start held high across a whole run.
      done_base = n_done_a;
      start_a   = 1'b1;
      tick();
      check("hold_c1", {busy_a, fail_a, err_a}, {1'b1, 1'b0, 4'd0});
      wait_done_a(1, 200, cyc);
      check("hold_done_cycle", cyc, 67);
      check("hold_pass", {pass_a, fail_a}, 2'b10);
      tick();
      check("hold_idle", {busy_a, done_a}, 2'b00);
      tick();
      check("hold_restart", {busy_a, we_a, addr_a}, {1'b1, 1'b1, 4'd0});
      start_a = 1'b0;
      wait_done_a(1, 200, cyc);
      check("hold_second_done_cycle", cyc, 67);
      tick();
      check("hold_done_pulses", n_done_a - done_base, 2);

      // Asynchronous reset in the middle of WRITE.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (9) tick();
      check("c10_write9", {busy_a, we_a, addr_a}, {1'b1, 1'b1, 4'd9});
      #2 reset_n = 1'b0;
      #1;
      check("reset_mid", {busy_a, done_a, pass_a, fail_a, to_a, we_a, addr_a, err_a, wdata_a}, 64'd0);
      tick();
      reset_n = 1'b1;
      tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a(1, 200, cyc);
      check("post_reset_done_cycle", cyc, 67);
      check("post_reset_flags", {pass_a, fail_a, to_a}, 3'b100);

      // Watchdog instance with a 20-cycle limit.
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      wait_done_b(1, 100, cyc);
      check("timeout_done_cycle", cyc, 22);
      check("timeout_flags", {to_b, fail_b, pass_b, busy_b, err_b}, {1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
      tick();
      check("timeout_hold", {done_b, to_b, fail_b}, 3'b011);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
